// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_e : fetch FSM state encoding. The control unit and benches
//                   use these names so the numeric encoding lives in one place.
//   IF_ADDR_WIDTH / IF_DATA_WIDTH / IF_RESET_PC : default sizing.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam int          IF_ADDR_WIDTH = 16;
   localparam int          IF_DATA_WIDTH = 16;
   localparam logic [15:0] IF_RESET_PC   = 16'h0000;

   // IDLE : waiting for fetch/jump from the control unit
   // REQ  : memory read outstanding, memRead held until memReady
   // LOAD : instruction register load strobe cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LOAD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// ADDR_WIDTH program counter with asynchronous reset to RESET_PC.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   jump_load      : load jump_target
//   inc_load       : load inc_base + 1 (wraps modulo 2^ADDR_WIDTH)
//   jump_target    : jump destination
//   inc_base       : address just fetched
//   pc             : current program counter
// With neither load asserted the counter holds.
// -----------------------------------------------------------------------------
module program_counter #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  jump_load,
   input  logic                  inc_load,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic [ADDR_WIDTH-1:0] inc_base,
   output logic [ADDR_WIDTH-1:0] pc
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   // The two loads never coincide in the sequencer; the increment wins if
   // they ever did because it reflects a completed read.
   always_comb begin
      pc_d = pc_q;
      if (inc_load) begin
         pc_d = inc_base + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else if (jump_load) begin
         pc_d = jump_target;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch sequencer feeding the instruction register. Owns the PC, performs one
// handshaked memory read per fetch request, then strobes the instruction
// register's active-low load for one cycle.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   fetch, jump         : control unit requests, sampled only in IDLE
//   jumpTarget          : jump destination
//   memAddr, memRead    : registered read address / read request
//   memReady, memData   : memory acknowledge and same-cycle read data
//   instrData           : word driven to instruction register data input
//   notIrLoad           : active-low one-cycle load strobe
//   fetchDone           : one-cycle pulse coincident with notIrLoad low
//   busy                : high whenever not IDLE
//   pc                  : current program counter
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = IF_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = IF_RESET_PC
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jumpTarget,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memRead,
   input  logic                  memReady,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic [DATA_WIDTH-1:0] instrData,
   output logic                  notIrLoad,
   output logic                  fetchDone,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] pc
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
   logic                  mem_read_q, mem_read_d;
   logic                  not_ir_load_q, not_ir_load_d;
   logic                  fetch_done_q, fetch_done_d;
   logic                  busy_q, busy_d;

   logic                  pc_jump_load;
   logic                  pc_inc_load;
   logic [ADDR_WIDTH-1:0] pc_value;

   program_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_program_counter (
      .clock       (clock),
      .reset       (reset),
      .jump_load   (pc_jump_load),
      .inc_load    (pc_inc_load),
      .jump_target (jumpTarget),
      .inc_base    (mem_addr_q),
      .pc          (pc_value)
   );

   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      instr_data_d = instr_data_q;
      pc_jump_load = 1'b0;
      pc_inc_load  = 1'b0;

      case (state_q)
         IDLE: begin
            if (fetch) begin
               state_d = REQ;
               // A simultaneous jump redirects the fetch itself to the target.
               if (jump) begin
                  mem_addr_d   = jumpTarget;
                  pc_jump_load = 1'b1;
               end else begin
                  mem_addr_d = pc_value;
               end
            end else if (jump) begin
               pc_jump_load = 1'b1;
            end
         end
         REQ: begin
            if (memReady) begin
               instr_data_d = memData;
               pc_inc_load  = 1'b1;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes are flopped from the next state so each one is a pure
      // function of the state register: no input reaches an output.
      mem_read_d    = (state_d == REQ);
      not_ir_load_d = (state_d != LOAD);
      fetch_done_d  = (state_d == LOAD);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_addr_q    <= RESET_PC;
         instr_data_q  <= '0;
         mem_read_q    <= 1'b0;
         not_ir_load_q <= 1'b1;
         fetch_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         instr_data_q  <= instr_data_d;
         mem_read_q    <= mem_read_d;
         not_ir_load_q <= not_ir_load_d;
         fetch_done_q  <= fetch_done_d;
         busy_q        <= busy_d;
      end
   end

   assign memAddr   = mem_addr_q;
   assign memRead   = mem_read_q;
   assign instrData = instr_data_q;
   assign notIrLoad = not_ir_load_q;
   assign fetchDone = fetch_done_q;
   assign busy      = busy_q;
   assign pc        = pc_value;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Randomized and directed stimulus for instruction_fetch. The driver keeps a
// reference PC and pushes one expected read per accepted fetch; a monitor
// pops and compares whenever the DUT shows a read or a load strobe. A memory
// responder supplies a fixed address-derived data pattern with programmable
// wait states.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] pc_after;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch;
   logic        jump;
   logic [15:0] jumpTarget;
   logic [15:0] memAddr;
   logic        memRead;
   logic        memReady;
   logic [15:0] memData;
   logic [15:0] instrData;
   logic        notIrLoad;
   logic        fetchDone;
   logic        busy;
   logic [15:0] pc;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   logic [15:0] ref_pc;
   int   next_wait = 0;
   int   wait_cnt  = 0;
   logic prev_read = 1'b0;
   int   read_cycles = 0;
   int   done_cnt = 0;

   instruction_fetch #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .RESET_PC   (16'h0000)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .fetch      (fetch),
      .jump       (jump),
      .jumpTarget (jumpTarget),
      .memAddr    (memAddr),
      .memRead    (memRead),
      .memReady   (memReady),
      .memData    (memData),
      .instrData  (instrData),
      .notIrLoad  (notIrLoad),
      .fetchDone  (fetchDone),
      .busy       (busy),
      .pc         (pc)
   );

   always #5 clock = ~clock;

   // Memory contents: address 0 holds 16'hAF73, others an address hash.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [31:0] p;
      p = {16'h0000, a} * 32'd40503;
      return p[15:0] ^ 16'hAF73;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Memory responder
   always @(negedge clock) begin
      if (memRead && !prev_read) wait_cnt = next_wait;
      if (memRead) begin
         if (wait_cnt > 0) begin
            memReady = 1'b0;
            wait_cnt--;
         end else begin
            memReady = 1'b1;
         end
         memData = mem_word(memAddr);
      end else begin
         memReady = 1'($urandom_range(0, 1));
         memData  = 16'($urandom);
      end
      prev_read = memRead;
   end

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (!reset) begin
         if (memRead) begin
            read_cycles++;
            check("busy_in_req", {15'd0, busy}, 16'd1);
            check("not_ir_load_in_req", {15'd0, notIrLoad}, 16'd1);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_read: got addr %h expected no read", memAddr);
            end else begin
               check("mem_addr", memAddr, exp_q[0].addr);
            end
         end
         if (fetchDone) begin
            exp_t e;
            done_cnt++;
            check("not_ir_load_low", {15'd0, notIrLoad}, 16'd0);
            check("busy_in_load", {15'd0, busy}, 16'd1);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_load: got instr %h expected no load", instrData);
            end else begin
               e = exp_q.pop_front();
               check("instr_data", instrData, e.data);
               check("pc_in_load", pc, e.pc_after);
            end
         end else if (!memRead) begin
            check("not_ir_load_high", {15'd0, notIrLoad}, 16'd1);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy) begin
         total++; bad++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
      end
   endtask

   // Issue one command in IDLE and update the reference model.
   task automatic do_cmd(input logic f, input logic j, input logic [15:0] tgt);
      exp_t e;
      wait_idle();
      fetch = f;
      jump = j;
      jumpTarget = tgt;
      if (j) ref_pc = tgt;
      if (f) begin
         e.addr = ref_pc;
         e.data = mem_word(ref_pc);
         e.pc_after = ref_pc + 16'd1;
         exp_q.push_back(e);
         ref_pc = ref_pc + 16'd1;
      end
      @(negedge clock);
      fetch = 1'b0;
      jump = 1'b0;
      jumpTarget = 16'($urandom);
   endtask

   task automatic fetch_and_check(input logic j, input logic [15:0] tgt, input int w);
      int d0;
      next_wait = w;
      read_cycles = 0;
      d0 = done_cnt;
      do_cmd(1'b1, j, tgt);
      wait_idle();
      check("req_cycles", 16'(read_cycles), 16'(w + 1));
      check("load_pulses", 16'(done_cnt - d0), 16'd1);
      check("pc_after_fetch", pc, ref_pc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_read"}, {15'd0, memRead}, 16'd0);
      check({tag, "_not_ir_load"}, {15'd0, notIrLoad}, 16'd1);
      check({tag, "_fetch_done"}, {15'd0, fetchDone}, 16'd0);
      check({tag, "_busy"}, {15'd0, busy}, 16'd0);
      check({tag, "_pc"}, pc, 16'h0000);
      check({tag, "_mem_addr"}, memAddr, 16'h0000);
      check({tag, "_instr_data"}, instrData, 16'h0000);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      logic [15:0] saved_addr;
      reset = 1'b1;
      fetch = 1'b0;
      jump = 1'b0;
      jumpTarget = 16'h0000;
      memReady = 1'b0;
      memData = 16'h0000;
      ref_pc = 16'h0000;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clock);

      // Basic fetch from address 0, memory ready immediately
      fetch_and_check(1'b0, 16'h0000, 0);
      check("first_instr", instrData, 16'hAF73);

      // Five wait states
      fetch_and_check(1'b0, 16'h0000, 5);

      // Jump alone, then fetch
      do_cmd(1'b0, 1'b1, 16'h1234);
      check("pc_after_jump", pc, 16'h1234);
      check("busy_after_jump", {15'd0, busy}, 16'd0);
      fetch_and_check(1'b0, 16'h0000, 1);
      check("pc_1235", pc, 16'h1235);

      // Simultaneous jump and fetch
      fetch_and_check(1'b1, 16'h0040, 0);
      check("pc_0041", pc, 16'h0041);

      // Wrap at FFFF
      do_cmd(1'b0, 1'b1, 16'hFFFF);
      fetch_and_check(1'b0, 16'h0000, 2);
      check("pc_wrap", pc, 16'h0000);

      // Commands while busy are ignored
      next_wait = 4;
      saved_addr = ref_pc;
      do_cmd(1'b1, 1'b0, 16'h0000);
      @(negedge clock);
      fetch = 1'b1;
      jump = 1'b1;
      jumpTarget = 16'h7777;
      @(negedge clock);
      check("addr_held_busy", memAddr, saved_addr);
      fetch = 1'b0;
      jump = 1'b0;
      wait_idle();
      check("pc_ignore_busy", pc, saved_addr + 16'd1);

      // Back-to-back: fetch held high for 9 cycles yields 3 loads
      wait_idle();
      next_wait = 0;
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.addr = ref_pc;
         e.data = mem_word(ref_pc);
         e.pc_after = ref_pc + 16'd1;
         exp_q.push_back(e);
         ref_pc = ref_pc + 16'd1;
      end
      fetch = 1'b1;
      repeat (9) @(negedge clock);
      fetch = 1'b0;
      wait_idle();
      check("back_to_back_loads", 16'(done_cnt - d0), 16'd3);

      // Reset while in REQ
      next_wait = 20;
      do_cmd(1'b1, 1'b0, 16'h0000);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_in_req");
      exp_q.delete();
      ref_pc = 16'h0000;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Reset while in LOAD
      next_wait = 0;
      do_cmd(1'b1, 1'b1, 16'h0100);
      d0 = done_cnt;
      @(posedge clock);
      #1;
      check("load_reached", {15'd0, fetchDone}, 16'd1);
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_in_load");
      exp_q.delete();
      ref_pc = 16'h0000;
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("no_done_after_reset", 16'(done_cnt - d0), 16'd0);

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         int kind;
         logic [15:0] tgt;
         kind = $urandom_range(0, 3);
         tgt = 16'($urandom);
         if ($urandom_range(0, 7) == 0) tgt = 16'hFFFF;
         next_wait = $urandom_range(0, 3);
         case (kind)
            0: begin
               do_cmd(1'b0, 1'b1, tgt);
               check("rand_jump_pc", pc, ref_pc);
            end
            1: do_cmd(1'b1, 1'b0, 16'h0000);
            2: do_cmd(1'b1, 1'b1, tgt);
            default: begin
               do_cmd(1'b1, 1'b0, 16'h0000);
               fetch = 1'($urandom);
               jump = 1'($urandom);
               jumpTarget = 16'($urandom);
               @(negedge clock);
               fetch = 1'b0;
               jump = 1'b0;
            end
         endcase
      end
      wait_idle();
      @(negedge clock);
      check("final_pc", pc, ref_pc);
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
